// File: rtl/rs_parity_strip_pkg.sv
// Shared rx definitions for the RS parity stripper: default parity count, FSM states, par clamp.
package rs_parity_strip_pkg;

    localparam int RS_N        = 255;
    localparam int RS_K        = 239;
    localparam int PAR_DEFAULT = RS_N - RS_K;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    function automatic int unsigned clamp_par(input int unsigned cfg, input int unsigned par_max);
        return (cfg > par_max) ? par_max : cfg;
    endfunction

endpackage

// File: rtl/rs_strip_ringbuf.sv
// PAR_MAX-deep look-behind store; combinational read of the oldest symbol, read-before-write.
// Pointers advance together so rd_ptr always trails wr_ptr by the latched parity count.
module rs_strip_ringbuf #(
    parameter int DATA_W  = 8,
    parameter int PAR_MAX = 32,
    parameter int PAR_W   = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic              i_restart,
    input  logic [PAR_W-1:0]  i_par,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data
);
    localparam int PTR_W = (PAR_MAX > 1) ? $clog2(PAR_MAX) : 1;

    logic [DATA_W-1:0] r_mem [PAR_MAX];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  w_wr_addr;
    logic [PTR_W-1:0]  w_rd_restart;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(PAR_MAX - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A new codeword always starts at slot 0; the read pointer is preset to (1 - par) mod PAR_MAX.
    always_comb begin
        int v;
        v = 1 + PAR_MAX - int'(i_par);
        if (v >= PAR_MAX) v = v - PAR_MAX;
        w_rd_restart = PTR_W'(v);
    end

    assign w_wr_addr = i_restart ? '0 : r_wr_ptr;
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_wr_en) begin
            r_wr_ptr <= ptr_inc(w_wr_addr);
            r_rd_ptr <= i_restart ? w_rd_restart : ptr_inc(r_rd_ptr);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) r_mem[w_wr_addr] <= i_wr_data;
    end

endmodule

// File: rtl/rs_parity_strip.sv
// Strips trailing RS parity symbols per codeword and re-frames SOF/EOF on data; 1-cycle registered latency.
// No backpressure: every valid beat is consumed; output follows the releasing beat by one cycle.
module rs_parity_strip
    import rs_parity_strip_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PAR_MAX = 32,
    parameter int PAR_W   = 6,
    parameter int OCC_W   = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [PAR_W-1:0]  i_cfg_par,
    input  logic [DATA_W-1:0] i_rs_de_data,
    input  logic              i_rs_de_data_valid,
    input  logic              i_rs_de_sof,
    input  logic              i_rs_de_eof,
    input  logic              i_rs_de_err,
    output logic [DATA_W-1:0] o_rs_re_data,
    output logic              o_rs_re_data_valid,
    output logic              o_rs_re_sof,
    output logic              o_rs_re_eof,
    output logic              o_rs_re_err,
    output logic              o_short,
    output logic              o_trunc
);
    state_t            r_state, w_state_nxt;
    logic [OCC_W-1:0]  r_occ, w_occ_nxt, w_occ_inc;
    logic [PAR_W-1:0]  r_par, w_par_nxt, w_par_cfg;
    logic              r_first, w_first_nxt;
    logic [DATA_W-1:0] w_dat_nxt, w_rd_data;
    logic              w_vld_nxt, w_sof_nxt, w_eof_nxt, w_err_nxt, w_short_nxt, w_trunc_nxt;
    logic              w_wr_en, w_restart;

    assign w_par_cfg = PAR_W'(clamp_par(32'(i_cfg_par), PAR_MAX));
    assign w_occ_inc = r_occ + OCC_W'(1);

    rs_strip_ringbuf #(
        .DATA_W  (DATA_W),
        .PAR_MAX (PAR_MAX),
        .PAR_W   (PAR_W)
    ) u_ringbuf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_wr_en),
        .i_restart (w_restart),
        .i_par     (w_par_cfg),
        .i_wr_data (i_rs_de_data),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_occ_nxt   = r_occ;
        w_par_nxt   = r_par;
        w_first_nxt = r_first;
        w_dat_nxt   = o_rs_re_data;
        w_vld_nxt   = 1'b0;
        w_sof_nxt   = 1'b0;
        w_eof_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_short_nxt = 1'b0;
        w_trunc_nxt = 1'b0;
        w_wr_en     = 1'b0;
        w_restart   = 1'b0;

        if (i_rs_de_data_valid) begin
            if (i_rs_de_sof) begin
                w_wr_en     = 1'b1;
                w_restart   = 1'b1;
                w_par_nxt   = w_par_cfg;
                w_occ_nxt   = OCC_W'(1);
                w_first_nxt = 1'b1;
                w_trunc_nxt = (r_state != ST_IDLE);
                if (w_par_cfg == '0) begin
                    // Zero parity: the SOF symbol is data and leaves immediately.
                    w_vld_nxt   = 1'b1;
                    w_sof_nxt   = 1'b1;
                    w_dat_nxt   = i_rs_de_data;
                    w_first_nxt = 1'b0;
                    w_state_nxt = ST_STREAM;
                    if (i_rs_de_eof) begin
                        w_eof_nxt   = 1'b1;
                        w_err_nxt   = i_rs_de_err;
                        w_occ_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (i_rs_de_eof) begin
                    w_short_nxt = 1'b1;
                    w_first_nxt = 1'b0;
                    w_occ_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = (w_par_cfg == PAR_W'(1)) ? ST_STREAM : ST_FILL;
                end
            end else begin
                case (r_state)
                    ST_FILL: begin
                        w_wr_en   = 1'b1;
                        w_occ_nxt = w_occ_inc;
                        if (i_rs_de_eof) begin
                            w_short_nxt = 1'b1;
                            w_first_nxt = 1'b0;
                            w_occ_nxt   = '0;
                            w_state_nxt = ST_IDLE;
                        end else if (32'(w_occ_inc) == 32'(r_par)) begin
                            w_state_nxt = ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        w_wr_en     = 1'b1;
                        w_vld_nxt   = 1'b1;
                        w_dat_nxt   = (r_par == '0) ? i_rs_de_data : w_rd_data;
                        w_sof_nxt   = r_first;
                        w_first_nxt = 1'b0;
                        if (i_rs_de_eof) begin
                            w_eof_nxt   = 1'b1;
                            w_err_nxt   = i_rs_de_err;
                            w_occ_nxt   = '0;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state            <= ST_IDLE;
            r_occ              <= '0;
            r_par              <= '0;
            r_first            <= 1'b0;
            o_rs_re_data       <= '0;
            o_rs_re_data_valid <= 1'b0;
            o_rs_re_sof        <= 1'b0;
            o_rs_re_eof        <= 1'b0;
            o_rs_re_err        <= 1'b0;
            o_short            <= 1'b0;
            o_trunc            <= 1'b0;
        end else begin
            r_state            <= w_state_nxt;
            r_occ              <= w_occ_nxt;
            r_par              <= w_par_nxt;
            r_first            <= w_first_nxt;
            o_rs_re_data       <= w_dat_nxt;
            o_rs_re_data_valid <= w_vld_nxt;
            o_rs_re_sof        <= w_sof_nxt;
            o_rs_re_eof        <= w_eof_nxt;
            o_rs_re_err        <= w_err_nxt;
            o_short            <= w_short_nxt;
            o_trunc            <= w_trunc_nxt;
        end
    end

endmodule

// File: tb/tb_rs_parity_strip.sv
// Directed self-checking bench for rs_parity_strip; per-cycle output vector compared against hand-derived values.
module tb_rs_parity_strip;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [5:0] i_cfg_par = '0;
    logic [7:0] i_rs_de_data = '0;
    logic       i_rs_de_data_valid = 1'b0;
    logic       i_rs_de_sof = 1'b0;
    logic       i_rs_de_eof = 1'b0;
    logic       i_rs_de_err = 1'b0;
    logic [7:0] o_rs_re_data;
    logic       o_rs_re_data_valid, o_rs_re_sof, o_rs_re_eof, o_rs_re_err, o_short, o_trunc;

    int n_checks = 0;
    int n_errors = 0;

    rs_parity_strip dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_cfg_par          (i_cfg_par),
        .i_rs_de_data       (i_rs_de_data),
        .i_rs_de_data_valid (i_rs_de_data_valid),
        .i_rs_de_sof        (i_rs_de_sof),
        .i_rs_de_eof        (i_rs_de_eof),
        .i_rs_de_err        (i_rs_de_err),
        .o_rs_re_data       (o_rs_re_data),
        .o_rs_re_data_valid (o_rs_re_data_valid),
        .o_rs_re_sof        (o_rs_re_sof),
        .o_rs_re_eof        (o_rs_re_eof),
        .o_rs_re_err        (o_rs_re_err),
        .o_short            (o_short),
        .o_trunc            (o_trunc)
    );

    always #5 i_clk = ~i_clk;

    // Applies one cycle of input, then waits until just after the edge that registers its result.
    task automatic beat(input logic v, input logic s, input logic e, input logic er,
                        input logic [7:0] d, input logic [5:0] c);
        i_rs_de_data_valid = v;
        i_rs_de_sof        = s;
        i_rs_de_eof        = e;
        i_rs_de_err        = er;
        i_rs_de_data       = d;
        i_cfg_par          = c;
        @(posedge i_clk);
        #1;
    endtask

    // Output vector layout: {valid, sof, eof, err, short, trunc, data (zero when not valid)}.
    function automatic logic [13:0] got_vec();
        return {o_rs_re_data_valid, o_rs_re_sof, o_rs_re_eof, o_rs_re_err, o_short, o_trunc,
                o_rs_re_data_valid ? o_rs_re_data : 8'h00};
    endfunction

    task automatic test_reset();
        logic [13:0] g;
        i_rst = 1'b1;
        beat(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, 6'd0);
        beat(1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 6'd0);
        g = got_vec();
        n_checks++;
        if (g !== 14'h0 || o_rs_re_data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_outputs got=%h data=%h exp=0", g, o_rs_re_data);
        end
        i_rst = 1'b0;
        beat(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0);
        g = got_vec();
        n_checks++;
        if (g !== 14'h0) begin
            n_errors++;
            $display("FAIL reset_idle got=%h exp=0", g);
        end
    endtask

    task automatic test_full_codeword();
        logic [13:0] g, x;
        int n_out = 0;
        for (int k = 0; k < 255; k++) begin
            beat(1'b1, k == 0, k == 254, 1'b0, 8'(k), 6'd16);
            x = (k >= 16) ? {1'b1, k == 16, k == 254, 1'b0, 2'b00, 8'(k - 16)} : 14'h0;
            g = got_vec();
            if (o_rs_re_data_valid) n_out++;
            n_checks++;
            if (g !== x) begin
                n_errors++;
                $display("FAIL full k=%0d got=%h exp=%h", k, g, x);
            end
        end
        n_checks++;
        if (n_out !== 239) begin
            n_errors++;
            $display("FAIL full_count got=%0d exp=239", n_out);
        end
        beat(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0);
    endtask

    task automatic test_shortened();
        logic [13:0] g, x;
        for (int k = 0; k < 20; k++) begin
            beat(1'b1, k == 0, k == 19, k == 19, 8'(k + 1), 6'd16);
            x = (k >= 16) ? {1'b1, k == 16, k == 19, k == 19, 2'b00, 8'(k - 15)} : 14'h0;
            g = got_vec();
            n_checks++;
            if (g !== x) begin
                n_errors++;
                $display("FAIL shortened k=%0d got=%h exp=%h", k, g, x);
            end
        end
    endtask

    task automatic test_par0_gaps();
        logic [13:0] g, x;
        for (int i = 0; i < 5; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int j = 0; j < gap; j++) begin
                beat(1'b0, 1'b0, 1'b0, 1'b0, 8'hEE, 6'd0);
                g = got_vec();
                n_checks++;
                if (g !== 14'h0) begin
                    n_errors++;
                    $display("FAIL par0_idle i=%0d got=%h exp=0", i, g);
                end
            end
            beat(1'b1, i == 0, i == 4, 1'b0, 8'(8'h10 + i), 6'd0);
            x = {1'b1, i == 0, i == 4, 1'b0, 2'b00, 8'(8'h10 + i)};
            g = got_vec();
            n_checks++;
            if (g !== x) begin
                n_errors++;
                $display("FAIL par0_beat i=%0d got=%h exp=%h", i, g, x);
            end
        end
        beat(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0);
    endtask

    task automatic test_short_len1();
        logic [13:0] g, x;
        for (int k = 0; k < 6; k++) begin
            beat(1'b1, k == 0, k == 5, 1'b1, 8'(8'h30 + k), 6'd8);
            x = (k == 5) ? 14'b00_0010_0000_0000 : 14'h0;
            g = got_vec();
            n_checks++;
            if (g !== x) begin
                n_errors++;
                $display("FAIL short k=%0d got=%h exp=%h", k, g, x);
            end
        end
        beat(1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 6'd0);
        x = {1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 8'h5A};
        g = got_vec();
        n_checks++;
        if (g !== x) begin
            n_errors++;
            $display("FAIL len1 got=%h exp=%h", g, x);
        end
        beat(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0);
        g = got_vec();
        n_checks++;
        if (g !== 14'h0) begin
            n_errors++;
            $display("FAIL len1_after got=%h exp=0", g);
        end
    endtask

    task automatic test_trunc_back_to_back();
        logic [13:0] g, x;
        for (int k = 0; k < 10; k++) begin
            beat(1'b1, k == 0, 1'b0, 1'b0, 8'(8'h20 + k), 6'd4);
            x = (k >= 4) ? {1'b1, k == 4, 1'b0, 1'b0, 2'b00, 8'(8'h20 + k - 4)} : 14'h0;
            g = got_vec();
            n_checks++;
            if (g !== x) begin
                n_errors++;
                $display("FAIL trunc_first k=%0d got=%h exp=%h", k, g, x);
            end
        end
        for (int k = 0; k < 8; k++) begin
            beat(1'b1, k == 0, k == 7, 1'b0, 8'(8'h40 + k), 6'd4);
            x = (k >= 4) ? {1'b1, k == 4, k == 7, 1'b0, 2'b00, 8'(8'h40 + k - 4)}
                         : {5'b0, k == 0, 8'h00};
            g = got_vec();
            n_checks++;
            if (g !== x) begin
                n_errors++;
                $display("FAIL trunc_second k=%0d got=%h exp=%h", k, g, x);
            end
        end
        for (int k = 0; k < 5; k++) begin
            beat(1'b1, k == 0, k == 4, 1'b0, 8'(8'h60 + k), 6'd2);
            x = (k >= 2) ? {1'b1, k == 2, k == 4, 1'b0, 2'b00, 8'(8'h60 + k - 2)} : 14'h0;
            g = got_vec();
            n_checks++;
            if (g !== x) begin
                n_errors++;
                $display("FAIL b2b k=%0d got=%h exp=%h", k, g, x);
            end
        end
    endtask

    task automatic test_clamp();
        logic [13:0] g, x;
        for (int k = 0; k < 35; k++) begin
            beat(1'b1, k == 0, k == 34, 1'b0, 8'(8'h80 + k), 6'd40);
            x = (k >= 32) ? {1'b1, k == 32, k == 34, 1'b0, 2'b00, 8'(8'h80 + k - 32)} : 14'h0;
            g = got_vec();
            n_checks++;
            if (g !== x) begin
                n_errors++;
                $display("FAIL clamp k=%0d got=%h exp=%h", k, g, x);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [13:0] g, x;
        for (int k = 0; k < 6; k++) begin
            beat(1'b1, k == 0, 1'b0, 1'b0, 8'(8'hC0 + k), 6'd4);
            x = (k >= 4) ? {1'b1, k == 4, 1'b0, 1'b0, 2'b00, 8'(8'hC0 + k - 4)} : 14'h0;
            g = got_vec();
            n_checks++;
            if (g !== x) begin
                n_errors++;
                $display("FAIL rstmid_pre k=%0d got=%h exp=%h", k, g, x);
            end
        end
        i_rst = 1'b1;
        beat(1'b1, 1'b0, 1'b0, 1'b0, 8'hC6, 6'd4);
        g = got_vec();
        n_checks++;
        if (g !== 14'h0 || o_rs_re_data !== 8'h00) begin
            n_errors++;
            $display("FAIL rstmid_outputs got=%h data=%h exp=0", g, o_rs_re_data);
        end
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            beat(1'b1, 1'b0, k == 2, 1'b0, 8'(8'hD0 + k), 6'd0);
            g = got_vec();
            n_checks++;
            if (g !== 14'h0) begin
                n_errors++;
                $display("FAIL rstmid_drop k=%0d got=%h exp=0", k, g);
            end
        end
        for (int k = 0; k < 3; k++) begin
            beat(1'b1, k == 0, k == 2, 1'b0, 8'(8'h70 + k), 6'd1);
            x = (k >= 1) ? {1'b1, k == 1, k == 2, 1'b0, 2'b00, 8'(8'h70 + k - 1)} : 14'h0;
            g = got_vec();
            n_checks++;
            if (g !== x) begin
                n_errors++;
                $display("FAIL rstmid_post k=%0d got=%h exp=%h", k, g, x);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_codeword();
        test_shortened();
        test_par0_gaps();
        test_short_len1();
        test_trunc_back_to_back();
        test_clamp();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
